// File: rtl/main_mem_line.sv
// Main memory line model: one request at a time, fixed latency, full-line response.
// Optional MAIN_MEM_CRIT_WORD_FIRST_EN rotates the line so word 0 is the requested word.
module main_mem_line #(
  parameter int ADDR_W  = 32,
  parameter int WORD_W  = 32,
  parameter int WORDS   = 16,
  parameter int LATENCY = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_W-1:0]       req_addr,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [WORDS*WORD_W-1:0] resp_data,
  output logic [ADDR_W-1:0]       resp_addr,
  output logic [15:0]             req_count
);

  localparam int OFF_W = $clog2(WORDS);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state;
  state_t state_nx;

  logic [7:0]              cnt;
  logic [ADDR_W-1:0]       addr_q;
  logic [ADDR_W-1:0]       base;
  logic [WORDS*WORD_W-1:0] line_w;
  logic                    acc;
  logic                    done;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign acc        = req_valid && req_ready;
  assign done       = resp_valid && resp_ready;
  assign base       = addr_q & ~ADDR_W'(WORDS - 1);

`ifdef MAIN_MEM_CRIT_WORD_FIRST_EN
  logic [OFF_W-1:0] off;
  assign off = addr_q[OFF_W-1:0];
`endif

  // Build every word of the line from the latched address
  for (genvar g = 0; g < WORDS; g++) begin : g_word
    logic [ADDR_W-1:0] word_a;
`ifdef MAIN_MEM_CRIT_WORD_FIRST_EN
    logic [OFF_W-1:0] idx;
    assign idx    = off + OFF_W'(g);
    assign word_a = base | ADDR_W'(idx);
`else
    assign word_a = base + ADDR_W'(g);
`endif
    assign line_w[g*WORD_W +: WORD_W] = WORD_W'(word_a);
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (req_valid)  state_nx = WAIT;
      WAIT:    if (cnt == 8'd0) state_nx = RESP;
      RESP:    if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Address latch, latency counter, response capture and completion count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      cnt       <= '0;
      resp_data <= '0;
      resp_addr <= '0;
      req_count <= '0;
    end else begin
      if (acc) begin
        addr_q <= req_addr;
        cnt    <= 8'(LATENCY - 1);
      end
      if (state == WAIT) begin
        if (cnt == 8'd0) begin
          resp_data <= line_w;
          resp_addr <= base;
        end else begin
          cnt <= cnt - 8'd1;
        end
      end
      if (done) req_count <= req_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_main_mem_line.sv
// Directed bench for main_mem_line: default build and a small LATENCY=1 instance.
// Define MAIN_MEM_CRIT_WORD_FIRST_EN to check the rotated ordering.
module tb_main_mem_line;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [31:0]  req_addr = '0;
  logic         resp_valid;
  logic         resp_ready = 1'b0;
  logic [511:0] resp_data;
  logic [31:0]  resp_addr;
  logic [15:0]  req_count;

  logic         s_req_valid = 1'b0;
  logic         s_req_ready;
  logic [15:0]  s_req_addr = '0;
  logic         s_resp_valid;
  logic         s_resp_ready = 1'b0;
  logic [63:0]  s_resp_data;
  logic [15:0]  s_resp_addr;
  logic [15:0]  s_req_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  main_mem_line dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_addr  (resp_addr),
    .req_count  (req_count)
  );

  main_mem_line #(
    .ADDR_W  (16),
    .WORD_W  (16),
    .WORDS   (4),
    .LATENCY (1)
  ) dut_s (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (s_req_valid),
    .req_ready  (s_req_ready),
    .req_addr   (s_req_addr),
    .resp_valid (s_resp_valid),
    .resp_ready (s_resp_ready),
    .resp_data  (s_resp_data),
    .resp_addr  (s_resp_addr),
    .req_count  (s_req_count)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_w(input logic [31:0] a, input int k);
    logic [31:0] b;
    b = a & 32'hFFFF_FFF0;
`ifdef MAIN_MEM_CRIT_WORD_FIRST_EN
    return b + 32'((int'(a[3:0]) + k) % 16);
`else
    return b + 32'(k);
`endif
  endfunction

  function automatic logic [31:0] word(input int k);
    return resp_data[k*32 +: 32];
  endfunction

  // Present a request; returns just after the accepting edge
  task automatic send(input logic [31:0] a);
    check("req_ready_before", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_addr  = a;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Check that resp_valid rises exactly four edges after acceptance
  task automatic wait_resp(input string tag);
    for (int i = 1; i < 4; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_early"}, 64'(resp_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    check({tag, "_valid"}, 64'(resp_valid), 64'd1);
  endtask

  task automatic complete(input string tag, input logic [15:0] cnt_exp);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    check({tag, "_count"}, 64'(req_count), 64'(cnt_exp));
    check({tag, "_done"}, 64'(resp_valid), 64'd0);
    check({tag, "_rdy"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    int seen;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_valid", 64'(resp_valid), 64'd0);
    check("rst_addr", 64'(resp_addr), 64'd0);
    check("rst_data", 64'(resp_data[63:0]), 64'd0);
    check("rst_count", 64'(req_count), 64'd0);
    rst = 1'b0;

    // Basic read of a mid-line address
    @(negedge clk);
    send(32'h0000_0025);
    wait_resp("basic");
    check("basic_addr", 64'(resp_addr), 64'h20);
    for (int k = 0; k < 16; k++)
      check($sformatf("basic_w%0d", k), 64'(word(k)),
            64'(exp_w(32'h25, k)));
`ifdef MAIN_MEM_CRIT_WORD_FIRST_EN
    check("cwf_w0", 64'(word(0)), 64'h25);
    check("cwf_w10", 64'(word(10)), 64'h2F);
    check("cwf_w11", 64'(word(11)), 64'h20);
    check("cwf_w15", 64'(word(15)), 64'h24);
`else
    check("basic_w0c", 64'(word(0)), 64'h20);
    check("basic_w15c", 64'(word(15)), 64'h2F);
`endif
    complete("basic", 16'd1);

    // Top-of-space line
    send(32'hFFFF_FFFF);
    wait_resp("wrap");
    check("wrap_addr", 64'(resp_addr), 64'hFFFF_FFF0);
    check("wrap_x", 64'($isunknown(resp_data)), 64'd0);
    for (int k = 0; k < 16; k++)
      check($sformatf("wrap_w%0d", k), 64'(word(k)),
            64'(exp_w(32'hFFFF_FFFF, k)));
    complete("wrap", 16'd2);

    // Backpressure with a competing request held during WAIT/RESP
    send(32'h0000_0040);
    req_valid = 1'b1;
    req_addr  = 32'h0000_0100;
    for (int i = 1; i < 4; i++) begin
      @(posedge clk);
      #1;
      check("busy_ready", 64'(req_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    check("bp_valid", 64'(resp_valid), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_v", 64'(resp_valid), 64'd1);
      check("bp_hold_a", 64'(resp_addr), 64'h40);
      check("bp_hold_d", 64'(word(3)), 64'(exp_w(32'h40, 3)));
    end
    req_valid = 1'b0;
    complete("bp", 16'd3);
    check("bp_keep_d", 64'(word(3)), 64'(exp_w(32'h40, 3)));

    // Reset two cycles into WAIT abandons the transaction
    send(32'h0000_0080);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(resp_valid), 64'd0);
    check("mid_rst_count", 64'(req_count), 64'd0);
    check("mid_rst_data", 64'(resp_data[63:0]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid) seen = 1;
    end
    check("mid_rst_noresp", 64'(seen), 64'd0);

    // Acceptance on the first edge after reset release
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 1'b1;
    req_addr  = 32'h0000_0025;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    wait_resp("post_rst");
    check("post_rst_addr", 64'(resp_addr), 64'h20);
    complete("post_rst", 16'd1);

    // Small instance: LATENCY=1, WORDS=4, WORD_W=16
    check("s_ready", 64'(s_req_ready), 64'd1);
    s_req_valid = 1'b1;
    s_req_addr  = 16'h0007;
    @(posedge clk);
    #1;
    s_req_valid = 1'b0;
    check("s_early", 64'(s_resp_valid), 64'd0);
    @(posedge clk);
    #1;
    check("s_valid", 64'(s_resp_valid), 64'd1);
    check("s_addr", 64'(s_resp_addr), 64'h0004);
`ifdef MAIN_MEM_CRIT_WORD_FIRST_EN
    check("s_data", s_resp_data, 64'h0006_0005_0004_0007);
`else
    check("s_data", s_resp_data, 64'h0007_0006_0005_0004);
`endif
    s_resp_ready = 1'b1;
    @(posedge clk);
    #1;
    s_resp_ready = 1'b0;
    check("s_count", 64'(s_req_count), 64'd1);
    check("s_rdy", 64'(s_req_ready), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
